// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions for the control sequencer: opcodes, instruction field layout
// and sequencer states.
package control_sequencer_pkg;

   localparam int unsigned CHOICE_WIDTH = 2;
   localparam int unsigned RSVD_WIDTH   = 4;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_JMP  = 6'h20;
   localparam logic [5:0] OP_JZ   = 6'h21;
   localparam logic [5:0] OP_JNZ  = 6'h22;
   localparam logic [5:0] OP_CALL = 6'h23;
   localparam logic [5:0] OP_RET  = 6'h24;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic [1:0] {StFetch, StExec, StHalted, StFault} state_e;

   typedef enum logic [2:0] {
      FieldSrc2, FieldSrc1, FieldDst, FieldSrc2Choice, FieldSrc1Choice, FieldDstChoice,
      FieldOpcode
   } field_e;

   function automatic int unsigned instr_width(input int unsigned opcode_width,
                                               input int unsigned value_width);
      return opcode_width + 3 * CHOICE_WIDTH + 3 * value_width + RSVD_WIDTH;
   endfunction

   // Bit position of each field inside the full instruction word (reserved bits at the bottom).
   function automatic int unsigned field_lsb(input field_e field, input int unsigned value_width);
      int unsigned lsb;
      lsb = RSVD_WIDTH;
      case (field)
         FieldSrc2:       lsb = RSVD_WIDTH;
         FieldSrc1:       lsb = RSVD_WIDTH + value_width;
         FieldDst:        lsb = RSVD_WIDTH + 2 * value_width;
         FieldSrc2Choice: lsb = RSVD_WIDTH + 3 * value_width;
         FieldSrc1Choice: lsb = RSVD_WIDTH + 3 * value_width + CHOICE_WIDTH;
         FieldDstChoice:  lsb = RSVD_WIDTH + 3 * value_width + 2 * CHOICE_WIDTH;
         FieldOpcode:     lsb = RSVD_WIDTH + 3 * value_width + 3 * CHOICE_WIDTH;
         default:         lsb = RSVD_WIDTH;
      endcase
      return lsb;
   endfunction

endpackage

// File: rtl/control_sequencer_return_stack.sv
// LIFO of return addresses; push when full and pop when empty are ignored.
module return_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 5,
   localparam int unsigned SP_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [WIDTH-1:0]    push_data,
   output logic [WIDTH-1:0]    top_data,
   output logic [SP_WIDTH-1:0] sp,
   output logic                full,
   output logic                empty
);

   localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [SP_WIDTH-1:0] sp_q, sp_d, top_idx;

   assign full     = (sp_q == SP_WIDTH'(DEPTH));
   assign empty    = (sp_q == '0);
   assign sp       = sp_q;
   assign top_idx  = sp_q - SP_WIDTH'(1);
   assign top_data = mem_q[top_idx[IDX_WIDTH-1:0]];

   always_comb begin
      sp_d = sp_q;
      if (push && !full) begin
         sp_d = sp_q + SP_WIDTH'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - SP_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entries need no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[sp_q[IDX_WIDTH-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer: fetches instructions over a ready handshake, issues
// datapath ops, and resolves jumps, calls and returns against a small return stack.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = 5,
   parameter int unsigned STACK_DEPTH  = 4,
   parameter int unsigned OPCODE_WIDTH = 6,
   parameter int unsigned VALUE_WIDTH  = 8,
   parameter int unsigned RESET_VECTOR = 0,
   localparam int unsigned INSTR_WIDTH = instr_width(OPCODE_WIDTH, VALUE_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    zero_flag,
   output logic [PC_WIDTH-1:0]     imem_addr,
   output logic                    imem_req,
   input  logic                    imem_ready,
   input  logic [INSTR_WIDTH-1:0]  imem_data,
   output logic [OPCODE_WIDTH-1:0] op_code,
   output logic [VALUE_WIDTH-1:0]  source1,
   output logic [VALUE_WIDTH-1:0]  source2,
   output logic [VALUE_WIDTH-1:0]  destination,
   output logic [1:0]              source1_choice,
   output logic [1:0]              source2_choice,
   output logic [1:0]              destination_choice,
   output logic                    issue,
   output logic                    push,
   output logic                    pop,
   output logic                    halted,
   output logic                    fault
);

   localparam int unsigned SRC2_LSB = field_lsb(FieldSrc2, VALUE_WIDTH);
   localparam int unsigned SRC1_LSB = field_lsb(FieldSrc1, VALUE_WIDTH);
   localparam int unsigned DST_LSB  = field_lsb(FieldDst, VALUE_WIDTH);
   localparam int unsigned S2C_LSB  = field_lsb(FieldSrc2Choice, VALUE_WIDTH);
   localparam int unsigned S1C_LSB  = field_lsb(FieldSrc1Choice, VALUE_WIDTH);
   localparam int unsigned DC_LSB   = field_lsb(FieldDstChoice, VALUE_WIDTH);
   localparam int unsigned OP_LSB   = field_lsb(FieldOpcode, VALUE_WIDTH);
   localparam int unsigned SP_WIDTH = $clog2(STACK_DEPTH + 1);

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc, target, stack_top;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic                   stack_full, stack_empty, is_datapath;
   logic [SP_WIDTH-1:0]    unused_sp;
   logic [RSVD_WIDTH-1:0]  unused_rsvd;

   assign op_code            = ir_q[OP_LSB +: OPCODE_WIDTH];
   assign destination_choice = ir_q[DC_LSB +: CHOICE_WIDTH];
   assign source1_choice     = ir_q[S1C_LSB +: CHOICE_WIDTH];
   assign source2_choice     = ir_q[S2C_LSB +: CHOICE_WIDTH];
   assign destination        = ir_q[DST_LSB +: VALUE_WIDTH];
   assign source1            = ir_q[SRC1_LSB +: VALUE_WIDTH];
   assign source2            = ir_q[SRC2_LSB +: VALUE_WIDTH];
   assign unused_rsvd        = ir_q[RSVD_WIDTH-1:0];

   assign imem_addr = pc_q;
   assign pc_inc    = pc_q + PC_WIDTH'(1);
   assign target    = destination[PC_WIDTH-1:0];

   assign is_datapath = !((op_code == OPCODE_WIDTH'(OP_NOP))  ||
                          (op_code == OPCODE_WIDTH'(OP_JMP))  ||
                          (op_code == OPCODE_WIDTH'(OP_JZ))   ||
                          (op_code == OPCODE_WIDTH'(OP_JNZ))  ||
                          (op_code == OPCODE_WIDTH'(OP_CALL)) ||
                          (op_code == OPCODE_WIDTH'(OP_RET))  ||
                          (op_code == OPCODE_WIDTH'(OP_HALT)));

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_return_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top_data  (stack_top),
      .sp        (unused_sp),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         pc_q    <= PC_WIDTH'(RESET_VECTOR);
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         StFetch: begin
            if (imem_ready) begin
               ir_d    = imem_data;
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StFetch;
            pc_d    = pc_inc;
            case (op_code)
               OPCODE_WIDTH'(OP_JMP): pc_d = target;
               OPCODE_WIDTH'(OP_JZ):  if (zero_flag) pc_d = target;
               OPCODE_WIDTH'(OP_JNZ): if (!zero_flag) pc_d = target;
               OPCODE_WIDTH'(OP_CALL): begin
                  if (stack_full) begin
                     pc_d    = pc_q;
                     state_d = StFault;
                  end else begin
                     pc_d = target;
                  end
               end
               OPCODE_WIDTH'(OP_RET): begin
                  if (stack_empty) begin
                     pc_d    = pc_q;
                     state_d = StFault;
                  end else begin
                     pc_d = stack_top;
                  end
               end
               OPCODE_WIDTH'(OP_HALT): begin
                  pc_d    = pc_q;
                  state_d = StHalted;
               end
               default: ;
            endcase
         end
         StHalted: ;
         StFault:  ;
      endcase
   end

   // The reset term keeps imem_req low while rst holds the state in fetch.
   always_comb begin
      imem_req = 1'b0;
      issue    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      halted   = (state_q == StHalted);
      fault    = (state_q == StFault);
      case (state_q)
         StFetch: imem_req = !rst;
         StExec: begin
            issue = is_datapath;
            push  = (op_code == OPCODE_WIDTH'(OP_CALL)) && !stack_full;
            pop   = (op_code == OPCODE_WIDTH'(OP_RET)) && !stack_empty;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 5, program-counter width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (≥1).
REQ-003 SHALL have parameter OPCODE_WIDTH, default 6, opcode field width.
REQ-004 SHALL have parameter VALUE_WIDTH, default 8, register-id/value field width.
REQ-005 SHALL have parameter RESET_VECTOR, default 0, first fetch address.
REQ-006 SHALL derive INSTR_WIDTH = OPCODE_WIDTH + 6 + 3*VALUE_WIDTH + 4 (40 at defaults).
REQ-007 SHALL have one clock and an asynchronous, active-high reset: clk in 1 (all state on rising edge), then rst in 1.
REQ-008 zero_flag in 1: datapath zero result.
REQ-009 imem_addr out PC_WIDTH; imem_req out 1; imem_ready in 1; imem_data in INSTR_WIDTH: instruction-memory handshake.
REQ-010 op_code out OPCODE_WIDTH; source1, source2, destination out VALUE_WIDTH each; source1_choice, source2_choice, destination_choice out 2 each.
REQ-011 issue out 1: decoded fields valid for datapath this cycle.
REQ-012 push, pop out 1: single-cycle return-stack operation pulses.
REQ-013 halted out 1; fault out 1: sticky status.

Function
REQ-014 Instruction layout, MSB first: opcode, destination_choice, source1_choice, source2_choice, destination, source1, source2, 4 reserved bits (ignored).
REQ-015 States: FETCH, EXEC, HALTED, FAULT; reset enters FETCH.
REQ-016 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 latch imem_data into instruction register, go EXEC; else stay with imem_addr stable.
REQ-017 EXEC lasts exactly one cycle; zero-wait throughput is one instruction per 2 cycles.
REQ-018 Decoded outputs SHALL be driven from the instruction register and are meaningful only while issue=1.
REQ-019 EXEC, datapath opcode (not NOP/JMP/JZ/JNZ/CALL/RET/HALT): issue=1, pc←pc+1.
REQ-020 NOP: issue=0, pc←pc+1.
REQ-021 Jump target = low PC_WIDTH bits of destination field.
REQ-022 JMP: pc←target. JZ: pc←target if zero_flag=1 in EXEC cycle, else pc+1. JNZ: inverse.
REQ-023 CALL with sp<STACK_DEPTH: push=1, stack[sp]←pc+1, sp←sp+1, pc←target.
REQ-024 RET with sp>0: pop=1, pc←stack[sp-1], sp←sp-1.
REQ-025 CALL with sp=STACK_DEPTH (overflow) or RET with sp=0 (underflow): no push/pop, pc and sp unchanged, go FAULT.
REQ-026 HALT: go HALTED; halted=1.
REQ-027 HALTED and FAULT are terminal until rst; imem_req=0, issue/push/pop=0 there; fault=1 in FAULT.
REQ-028 pc+1 SHALL wrap modulo 2^PC_WIDTH (max address → 0), including stored return addresses.
REQ-029 issue, push, pop SHALL never be high outside EXEC; push and pop never simultaneously.
REQ-030 imem_data/imem_ready SHALL be ignored outside FETCH.

Reset
REQ-031 rst=1 asynchronously forces: state FETCH, pc=RESET_VECTOR, sp=0, instruction register 0 (all decoded outputs 0), imem_req=0, issue/push/pop/halted/fault=0.
REQ-032 Reset mid-fetch or mid-EXEC SHALL abandon the instruction with no stack or pc side effects; first fetch asserts imem_req on the first clk after rst falls.

Structure
REQ-033 Opcode constants (NOP=0x00, JMP=0x20, JZ=0x21, JNZ=0x22, CALL=0x23, RET=0x24, HALT=0x3F), field-position constants and state encoding SHALL live in the shared CPU definitions package.
REQ-034 Return stack SHALL be sub-module return_stack (STACK_DEPTH × PC_WIDTH, sp width clog2(STACK_DEPTH+1), full/empty outputs).

Verification
REQ-035 Zero-wait: ADD, SUB, NOP from address 0 -> issue high on cycles 2 and 4 with correct fields, no issue for NOP, imem_addr 0,1,2.
REQ-036 Wait states: imem_ready low 3 cycles at address 4 -> imem_addr held 4, imem_req held, no issue until the cycle after ready.
REQ-037 Branches: JZ 0x10 with zero_flag=1 -> next fetch 0x10; JNZ 0x10 with zero_flag=1 -> next fetch pc+1.
REQ-038 Nesting: 4 CALLs then 4 RETs -> 4 push pulses, returns to each call site+1 in LIFO order; 5th CALL -> fault=1, no push, imem_req=0.
REQ-039 Boundaries: RET at sp=0 -> fault; datapath op at pc=31 -> next fetch 0; CALL at 31 stores return address 0.
REQ-040 Reset: rst pulsed asynchronously during EXEC of CALL and in HALTED -> outputs zero immediately, sp=0, refetch from RESET_VECTOR.
